// File: rtl/usb_line_pkg.sv
// Shared line-state encodings and default 48 MHz timing for the USB line-state filter.
package usb_line_pkg;

    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_J   = 2'b01,
        LS_K   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_FILTER_LEN     = 3;
    localparam int DEF_EOP_MIN_CYCLES = 3;
    localparam int DEF_RESET_CYCLES   = 120;     // 2.5 us
    localparam int DEF_SUSPEND_CYCLES = 144000;  // 3 ms
    localparam int DEF_CNT_W          = 18;

    // Low-speed swaps which differential polarity counts as idle (J).
    function automatic line_state_e decode_line(input logic dp, input logic dn, input logic ls_mode);
        case ({dp, dn})
            2'b00:   decode_line = LS_SE0;
            2'b11:   decode_line = LS_SE1;
            2'b10:   decode_line = ls_mode ? LS_K : LS_J;
            default: decode_line = ls_mode ? LS_J : LS_K;
        endcase
    endfunction

endpackage

// File: rtl/usb_bit_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous pad input.
module usb_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: non-blocking assignments so every stage samples its predecessor's old value.
    always_ff @(posedge clk) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/usb_line_state_filter.sv
// Synchronised, glitch-filtered USB line-state decoder with EOP, bus-reset and suspend detection.
// Optional SE1 error reporting (se1_err, se1_cnt) is built when USB_LINE_SE1_ERR_EN is defined.
module usb_line_state_filter
    import usb_line_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int EOP_MIN_CYCLES = DEF_EOP_MIN_CYCLES,
    parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
    parameter int SUSPEND_CYCLES = DEF_SUSPEND_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_dp,
    input  logic       usb_dn,
    input  logic       ls_mode,
    output logic [1:0] line_state,
    output logic       state_chg,
    output logic       eop,
    output logic       bus_reset,
    output logic       suspend
`ifdef USB_LINE_SE1_ERR_EN
    ,
    output logic       se1_err,
    output logic [7:0] se1_cnt
`endif
);

    localparam int              FLT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FLT_W-1:0] FLT_MAX = FLT_W'(FILTER_LEN);
    localparam logic [CNT_W-1:0] EOP_MIN = CNT_W'(EOP_MIN_CYCLES);
    localparam logic [CNT_W-1:0] RST_MIN = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] SUS_MIN = CNT_W'(SUSPEND_CYCLES);

    logic             dp_s, dn_s;
    line_state_e      cand, prev_cand, ls_q, ls_nxt;
    logic [FLT_W-1:0] flt_cnt, flt_nxt;
    logic [CNT_W-1:0] run_cnt, run_nxt;
    logic             chg;
    logic             run_live;

    usb_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_dp (.clk(clk), .rst(rst), .d(usb_dp), .q(dp_s));
    usb_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_dn (.clk(clk), .rst(rst), .d(usb_dn), .q(dn_s));

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        cand    = decode_line(dp_s, dn_s, ls_mode);
        flt_nxt = FLT_W'(1);
        run_nxt = run_cnt;
        if (cand == prev_cand)
            flt_nxt = (flt_cnt >= FLT_MAX) ? FLT_MAX : flt_cnt + 1'b1;
        chg    = (flt_nxt >= FLT_MAX) && (cand != ls_q);
        ls_nxt = chg ? cand : ls_q;
        if (chg)
            run_nxt = CNT_W'(1);
        else if (!(&run_cnt))
            run_nxt = run_cnt + 1'b1;
    end

    // The SE0 held since reset was never observed starting, so it cannot end an EOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_cand <= LS_SE0;
            flt_cnt   <= '0;
            ls_q      <= LS_SE0;
            run_cnt   <= '0;
            run_live  <= 1'b0;
            state_chg <= 1'b0;
            eop       <= 1'b0;
            bus_reset <= 1'b0;
            suspend   <= 1'b0;
        end else begin
            prev_cand <= cand;
            flt_cnt   <= flt_nxt;
            ls_q      <= ls_nxt;
            run_cnt   <= run_nxt;
            run_live  <= run_live | chg;
            state_chg <= chg;
            eop       <= chg && (ls_q == LS_SE0) && (cand == LS_J) && run_live && (run_cnt >= EOP_MIN);
            bus_reset <= (ls_nxt == LS_SE0) && (run_nxt >= RST_MIN);
            suspend   <= (ls_nxt == LS_J) && (run_nxt >= SUS_MIN);
        end
    end

    assign line_state = ls_q;

`ifdef USB_LINE_SE1_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            se1_err <= 1'b0;
            se1_cnt <= '0;
        end else if (chg && (cand == LS_SE1)) begin
            se1_err <= 1'b1;
            if (se1_cnt != 8'hFF) se1_cnt <= se1_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_line_state_filter.sv
// Directed self-checking bench for usb_line_state_filter (SUSPEND_CYCLES reduced to 200).
module tb_usb_line_state_filter;
    import usb_line_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       usb_dp, usb_dn, ls_mode;
    logic [1:0] line_state;
    logic       state_chg, eop, bus_reset, suspend;
`ifdef USB_LINE_SE1_ERR_EN
    logic       se1_err;
    logic [7:0] se1_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    usb_line_state_filter #(.SUSPEND_CYCLES(200)) dut (
        .clk       (clk),
        .rst       (rst),
        .usb_dp    (usb_dp),
        .usb_dn    (usb_dn),
        .ls_mode   (ls_mode),
        .line_state(line_state),
        .state_chg (state_chg),
        .eop       (eop),
        .bus_reset (bus_reset),
        .suspend   (suspend)
`ifdef USB_LINE_SE1_ERR_EN
        ,
        .se1_err   (se1_err),
        .se1_cnt   (se1_cnt)
`endif
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clocks; sampling happens 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pins(input logic dp, input logic dn);
        usb_dp = dp;
        usb_dn = dn;
    endtask

    initial begin
        int bad;

        // 1: reset, then J appears SYNC_STAGES+FILTER_LEN = 5 cycles after release
        rst = 1'b1;
        ls_mode = 1'b0;
        pins(1'b1, 1'b0);
        step(3);
        check("rst_ls",   8'(line_state), 8'(LS_SE0));
        check("rst_chg",  8'(state_chg),  8'd0);
        check("rst_eop",  8'(eop),        8'd0);
        check("rst_br",   8'(bus_reset),  8'd0);
        check("rst_susp", 8'(suspend),    8'd0);
`ifdef USB_LINE_SE1_ERR_EN
        check("rst_se1e", 8'(se1_err),    8'd0);
        check("rst_se1c", se1_cnt,        8'd0);
`endif
        rst = 1'b0;
        step(4);
        check("j_early",  8'(line_state), 8'(LS_SE0));
        step(1);
        check("j_ls",     8'(line_state), 8'(LS_J));
        check("j_chg",    8'(state_chg),  8'd1);
        check("j_eop",    8'(eop),        8'd0);
        step(1);
        check("j_chg_off", 8'(state_chg), 8'd0);

        // 2: 2-cycle K glitch ignored, 4-cycle K accepted after 5 cycles
        step(3);
        pins(1'b0, 1'b1);
        step(2);
        pins(1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (line_state != LS_J || state_chg) bad++;
        end
        check("glitch", 8'(bad), 8'd0);
        pins(1'b0, 1'b1);
        step(4);
        pins(1'b1, 1'b0);
        check("k4_early", 8'(line_state), 8'(LS_J));
        step(1);
        check("k4_ls",    8'(line_state), 8'(LS_K));
        check("k4_chg",   8'(state_chg),  8'd1);
        step(10);
        check("k4_back",  8'(line_state), 8'(LS_J));

        // 3: 3-cycle SE0 then J gives eop; 2-cycle SE0 is filtered out
        pins(1'b0, 1'b0);
        step(3);
        pins(1'b1, 1'b0);
        step(4);
        check("eop_se0",  8'(line_state), 8'(LS_SE0));
        check("eop_pre",  8'(eop),        8'd0);
        step(1);
        check("eop_ls",   8'(line_state), 8'(LS_J));
        check("eop_set",  8'(eop),        8'd1);
        step(1);
        check("eop_off",  8'(eop),        8'd0);
        step(5);
        pins(1'b0, 1'b0);
        step(2);
        pins(1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (eop || line_state != LS_J) bad++;
        end
        check("eop_short", 8'(bad), 8'd0);

        // 4: long SE0 -> bus_reset at run 120, release -> cleared with eop
        pins(1'b0, 1'b0);
        step(123);
        check("br_pre",   8'(bus_reset),  8'd0);
        step(1);
        check("br_set",   8'(bus_reset),  8'd1);
        check("br_ls",    8'(line_state), 8'(LS_SE0));
        step(6);
        pins(1'b1, 1'b0);
        step(4);
        check("br_hold",  8'(bus_reset),  8'd1);
        step(1);
        check("br_rel_ls",  8'(line_state), 8'(LS_J));
        check("br_clr",     8'(bus_reset),  8'd0);
        check("br_rel_eop", 8'(eop),        8'd1);

        // 5: J for 250 cycles -> suspend at run 200, K clears it
        pins(1'b0, 1'b1);
        step(8);
        check("sus_k",    8'(line_state), 8'(LS_K));
        pins(1'b1, 1'b0);
        step(203);
        check("sus_pre",  8'(suspend),    8'd0);
        step(1);
        check("sus_set",  8'(suspend),    8'd1);
        step(46);
        pins(1'b0, 1'b1);
        step(4);
        check("sus_hold", 8'(suspend),    8'd1);
        step(1);
        check("sus_clr",  8'(suspend),    8'd0);
        check("sus_k_ls", 8'(line_state), 8'(LS_K));

        // 6: ls_mode flips J/K after FILTER_LEN cycles with static pins
        ls_mode = 1'b1;
        step(2);
        check("ls1_early", 8'(line_state), 8'(LS_K));
        step(1);
        check("ls1_j",     8'(line_state), 8'(LS_J));
        ls_mode = 1'b0;
        step(2);
        check("ls0_early", 8'(line_state), 8'(LS_J));
        step(1);
        check("ls0_k",     8'(line_state), 8'(LS_K));

        // SE1 is a legal state with no events
        pins(1'b1, 1'b1);
        step(5);
        check("se1_ls",   8'(line_state), 8'(LS_SE1));
        check("se1_chg",  8'(state_chg),  8'd1);
        check("se1_eop",  8'(eop),        8'd0);
`ifdef USB_LINE_SE1_ERR_EN
        check("se1_err",  8'(se1_err),    8'd1);
        check("se1_cnt",  se1_cnt,        8'd1);
`endif
        pins(1'b1, 1'b0);
        step(8);
        pins(1'b0, 1'b0);
        step(6);
        pins(1'b1, 1'b1);
        step(6);
        pins(1'b1, 1'b0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (eop) bad++;
        end
        check("se1_noeop", 8'(bad),        8'd0);
        check("se1_to_j",  8'(line_state), 8'(LS_J));
`ifdef USB_LINE_SE1_ERR_EN
        check("se1_cnt2",  se1_cnt,        8'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
